debug_gpr_access_seq: RTL and testbench

// Sequences Debug Module abstract GPR read/write commands onto the integer datapath's debug hooks.

---
 rtl/debug_gpr_access_seq_if.sv | 25 ++
 rtl/debug_gpr_access_seq.sv | 149 ++++++++++++++
 tb/tb_debug_gpr_access_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_gpr_access_seq_if.sv
// Debug Module command/response channel between the DM abstract-command
// logic (master) and the GPR access sequencer (slave).
interface debug_gpr_access_seq_if #(
    parameter int XLEN = 64
);
    logic            ReqValid;
    logic            ReqReady;
    logic            ReqWrite;
    logic [4:0]      ReqAddr;
    logic [XLEN-1:0] ReqData;
    logic            RspValid;
    logic            RspReady;
    logic [XLEN-1:0] RspData;
    logic            RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, RspReady,
        input  ReqReady, RspValid, RspData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, RspReady,
        output ReqReady, RspValid, RspData, RspErr
    );
endinterface

// File: rtl/debug_gpr_access_seq.sv
// Debug GPR access sequencer: turns one abstract GPR read/write command at a
// time into capture / scan / update strobes on the integer datapath's debug
// hooks, moving data LSB first through the XLEN-bit GPR scan register.
module debug_gpr_access_seq #(
    parameter int XLEN        = 64,
    parameter bit E_SUPPORTED = 1'b0
) (
    input  logic                     clk,
    input  logic                     resetn,
    debug_gpr_access_seq_if.slave    dm,
    input  logic                     CoreHalted,
    output logic                     GPRSel,
    output logic [4:0]               DebugRegAddr,
    output logic                     DebugCapture,
    output logic                     DebugScanEn,
    output logic                     DebugRegUpdate,
    output logic                     GPRScanIn,
    input  logic                     GPRScanOut
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_ERR,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    // Control state: async reset returns to IDLE so every strobe drops at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command/response payload; outputs are gated by state so no reset needed.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    // Next-state and strobe decode for the command sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        dm.ReqReady    = 1'b0;
        dm.RspValid    = 1'b0;
        dm.RspData     = '0;
        dm.RspErr      = 1'b0;
        GPRSel         = 1'b0;
        DebugCapture   = 1'b0;
        DebugScanEn    = 1'b0;
        DebugRegUpdate = 1'b0;
        GPRScanIn      = 1'b0;

        case (state_q)
            S_IDLE: begin
                dm.ReqReady = 1'b1;
                if (dm.ReqValid) begin
                    write_d = dm.ReqWrite;
                    addr_d  = dm.ReqAddr;
                    wdata_d = dm.ReqData;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!CoreHalted || (E_SUPPORTED && dm.ReqAddr[4]))
                        state_d = S_ERR;
                    else if (dm.ReqWrite)
                        state_d = S_SHIFT;
                    else
                        state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                GPRSel       = 1'b1;
                DebugCapture = 1'b1;
                if (!CoreHalted) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                GPRSel      = 1'b1;
                DebugScanEn = 1'b1;
                // Reads recirculate so the scan register ends up unchanged.
                GPRScanIn   = write_q ? wdata_q[cnt_q] : GPRScanOut;
                if (!write_q)
                    rdata_d[cnt_q] = GPRScanOut;
                if (!CoreHalted) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(XLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = write_q ? S_UPDATE : S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_UPDATE: begin
                // Halt loss here is ignored: the write is already committed.
                GPRSel         = 1'b1;
                DebugRegUpdate = 1'b1;
                state_d        = S_RESP;
            end
            S_ERR: begin
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                dm.RspValid = 1'b1;
                dm.RspData  = rdata_q;
                dm.RspErr   = err_q;
                if (dm.RspReady)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        DebugRegAddr = GPRSel ? addr_q : 5'd0;
    end
endmodule

// File: tb/tb_debug_gpr_access_seq.sv
// Randomised and directed bench for debug_gpr_access_seq with a behavioural
// register file / scan register on the datapath side and a response scoreboard.
module tb_debug_gpr_access_seq;
    localparam int XLEN  = 32;
    localparam bit E_SUP = 1'b1;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic            CoreHalted;
    logic            GPRSel, DebugCapture, DebugScanEn, DebugRegUpdate;
    logic            GPRScanIn, GPRScanOut;
    logic [4:0]      DebugRegAddr;

    debug_gpr_access_seq_if #(.XLEN(XLEN)) dm ();

    debug_gpr_access_seq #(.XLEN(XLEN), .E_SUPPORTED(E_SUP)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .dm             (dm),
        .CoreHalted     (CoreHalted),
        .GPRSel         (GPRSel),
        .DebugRegAddr   (DebugRegAddr),
        .DebugCapture   (DebugCapture),
        .DebugScanEn    (DebugScanEn),
        .DebugRegUpdate (DebugRegUpdate),
        .GPRScanIn      (GPRScanIn),
        .GPRScanOut     (GPRScanOut)
    );

    typedef struct {
        logic            err;
        logic [XLEN-1:0] data;
        int              lat;
        int              acc;
    } exp_t;

    exp_t            sbq[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              cyc = 0;
    logic [XLEN-1:0] ref_gpr [32];
    logic [XLEN-1:0] gpr [32];
    logic [XLEN-1:0] scan_q;
    logic            load_gpr = 1'b1;
    int              upd_cnt = 0, last_upd = -1, last_cap = -1, sel_cnt = 0;
    logic [4:0]      cur_addr = 5'd0;
    int              rdy_mode = 0;

    function automatic logic [XLEN-1:0] init_val(input int i);
        logic [31:0] v;
        v = (32'h9E37_79B9 * i) ^ 32'h5A5A_0F0F;
        return (i == 0) ? '0 : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath side: register file plus XLEN-bit scan register.
    always @(posedge clk) begin
        if (load_gpr) begin
            for (int i = 0; i < 32; i++) gpr[i] <= init_val(i);
            scan_q <= '0;
        end else begin
            if (DebugRegUpdate && DebugRegAddr != 5'd0) gpr[DebugRegAddr] <= scan_q;
            if (DebugCapture) scan_q <= gpr[DebugRegAddr];
            else if (DebugScanEn) scan_q <= {GPRScanIn, scan_q[XLEN-1:1]};
        end
    end
    assign GPRScanOut = scan_q[0];

    // Reference model: architectural effect of one command.
    task automatic predict(input bit wr, input logic [4:0] a, input logic [XLEN-1:0] d,
                           input bit halted, output exp_t e);
        e.err = 1'b0; e.data = '0; e.lat = XLEN + 2; e.acc = cyc;
        if (!halted || (E_SUP && a >= 5'd16)) begin
            e.err = 1'b1; e.lat = 2;
        end else if (wr) begin
            if (a != 5'd0) ref_gpr[a] = d;
        end else begin
            e.data = ref_gpr[a];
        end
    endtask

    // mode 0: predicted, 1: expect abort error (latency unchecked), 2: no expectation.
    task automatic do_cmd(input bit wr, input logic [4:0] a, input logic [XLEN-1:0] d,
                          input bit halted, input int mode, output int acc);
        int   w;
        bit   got;
        exp_t e;
        w = 0; got = 1'b0; acc = -1;
        @(negedge clk);
        dm.ReqValid = 1'b1; dm.ReqWrite = wr; dm.ReqAddr = a; dm.ReqData = d;
        while (!got && w < 400) begin
            if (dm.ReqReady) got = 1'b1;
            else begin @(negedge clk); w++; end
        end
        if (!got) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
            dm.ReqValid = 1'b0;
        end else begin
            CoreHalted = halted;
            cur_addr   = a;
            acc        = cyc;
            if (mode == 0) begin
                predict(wr, a, d, halted, e);
                sbq.push_back(e);
            end else if (mode == 1) begin
                e.err = 1'b1; e.data = '0; e.lat = -1; e.acc = cyc;
                sbq.push_back(e);
            end
            @(negedge clk);
            dm.ReqValid = 1'b0;
            dm.ReqWrite = 1'($urandom);
            dm.ReqAddr  = 5'($urandom);
            dm.ReqData  = $urandom;
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        do begin @(negedge clk); w++; end
        while (!(sbq.size() == 0 && dm.ReqReady) && w < 500);
        if (w >= 500) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Response-ready driver, updated just after the active edge.
    initial begin
        dm.RspReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       dm.RspReady = 1'b0;
                2:       dm.RspReady = 1'b1;
                default: dm.RspReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard monitor: latency on first RspValid, stability while stalled, data on handshake.
    initial begin
        bit              pv;
        logic [XLEN-1:0] hd;
        logic            he;
        exp_t            e;
        pv = 1'b0; hd = '0; he = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) pv = 1'b0;
            else if (dm.RspValid) begin
                if (!pv) begin
                    if (sbq.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                    else if (sbq[0].lat >= 0)
                        chk("rsp_latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                end else begin
                    chk("rsp_data_stable", 64'(dm.RspData), 64'(hd));
                    chk("rsp_err_stable", 64'(dm.RspErr), 64'(he));
                end
                hd = dm.RspData; he = dm.RspErr;
                if (dm.RspReady) begin
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("rsp_data", 64'(dm.RspData), 64'(e.data));
                        chk("rsp_err", 64'(dm.RspErr), 64'(e.err));
                    end
                    pv = 1'b0;
                end else pv = 1'b1;
            end else pv = 1'b0;
        end
    end

    // Debug-hook protocol watcher and event counters.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (DebugRegUpdate) begin upd_cnt++; last_upd = cyc; end
                if (DebugCapture) last_cap = cyc;
                if (GPRSel) begin
                    sel_cnt++;
                    chk("strobe_onehot", 64'($countones({DebugCapture, DebugScanEn, DebugRegUpdate}) <= 1), 64'd1);
                    chk("dbg_addr", 64'(DebugRegAddr), 64'(cur_addr));
                end else begin
                    chk("idle_hooks", 64'({DebugCapture, DebugScanEn, DebugRegUpdate, GPRScanIn, DebugRegAddr}), 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, u0, s0, k, w;
        logic [XLEN-1:0] old;
        dm.ReqValid = 1'b0; dm.ReqWrite = 1'b0; dm.ReqAddr = '0; dm.ReqData = '0;
        CoreHalted = 1'b1;
        for (int i = 0; i < 32; i++) ref_gpr[i] = init_val(i);
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ReqReady", 64'(dm.ReqReady), 64'd1);
        chk("rst_RspValid", 64'(dm.RspValid), 64'd0);
        chk("rst_RspData", 64'(dm.RspData), 64'd0);
        chk("rst_RspErr", 64'(dm.RspErr), 64'd0);
        chk("rst_hooks", 64'({GPRSel, DebugCapture, DebugScanEn, DebugRegUpdate, GPRScanIn, DebugRegAddr}), 64'd0);
        load_gpr = 1'b0;
        resetn   = 1'b1;

        // Write x5 then read it back.
        u0 = upd_cnt;
        do_cmd(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 0, acc);
        wait_done();
        chk("wr_upd_count", 64'(upd_cnt - u0), 64'd1);
        chk("wr_upd_cycle", 64'(last_upd - acc), 64'(XLEN + 1));
        chk("wr_gpr_x5", 64'(gpr[5]), 64'h0000_0000_DEAD_BEEF);
        chk("wr_scan_lsb_first", 64'(scan_q), 64'h0000_0000_DEAD_BEEF);

        do_cmd(1'b0, 5'd5, '0, 1'b1, 0, acc);
        wait_done();
        chk("rd_capture_cycle", 64'(last_cap - acc), 64'd1);
        chk("rd_gpr_kept", 64'(gpr[5]), 64'h0000_0000_DEAD_BEEF);
        chk("rd_scan_kept", 64'(scan_q), 64'h0000_0000_DEAD_BEEF);

        // Not halted: immediate error, datapath untouched.
        s0 = sel_cnt;
        do_cmd(1'b0, 5'd3, '0, 1'b0, 0, acc);
        wait_done();
        chk("nohalt_no_sel", 64'(sel_cnt - s0), 64'd0);

        // RV32E: x16 illegal, x15 fine.
        u0 = upd_cnt;
        do_cmd(1'b1, 5'd16, 32'h0BAD_0BAD, 1'b1, 0, acc);
        wait_done();
        chk("rv32e_no_upd", 64'(upd_cnt - u0), 64'd0);
        chk("rv32e_x16_kept", 64'(gpr[16]), 64'(init_val(16)));
        do_cmd(1'b0, 5'd15, '0, 1'b1, 0, acc);
        wait_done();

        // Halt lost mid-SHIFT on a write: error, no update.
        old = ref_gpr[7];
        u0  = upd_cnt;
        do_cmd(1'b1, 5'd7, 32'h1234_5678, 1'b1, 1, acc);
        k = 0; w = 0;
        while (k < 10 && w < 100) begin
            @(negedge clk); w++;
            if (DebugScanEn) k++;
        end
        CoreHalted = 1'b0;
        wait_done();
        chk("abort_no_upd", 64'(upd_cnt - u0), 64'd0);
        chk("abort_x7_kept", 64'(gpr[7]), 64'(old));
        do_cmd(1'b0, 5'd7, '0, 1'b1, 0, acc);
        wait_done();

        // Halt lost during UPDATE: write still lands.
        do_cmd(1'b1, 5'd11, 32'hA5A5_1234, 1'b1, 0, acc);
        w = 0;
        while (!DebugRegUpdate && w < 100) begin @(negedge clk); w++; end
        CoreHalted = 1'b0;
        wait_done();
        chk("upd_halt_drop_x11", 64'(gpr[11]), 64'h0000_0000_A5A5_1234);

        // Reset in the middle of a write shift.
        do_cmd(1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 2, acc);
        repeat (5) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_ReqReady", 64'(dm.ReqReady), 64'd1);
        chk("midrst_hooks", 64'({GPRSel, DebugCapture, DebugScanEn, DebugRegUpdate}), 64'd0);
        chk("midrst_RspValid", 64'(dm.RspValid), 64'd0);
        sbq.delete();
        @(negedge clk);
        resetn = 1'b1;
        chk("midrst_x9_kept", 64'(gpr[9]), 64'(init_val(9)));

        // Stalled read response.
        rdy_mode = 1;
        do_cmd(1'b0, 5'd9, '0, 1'b1, 0, acc);
        w = 0;
        while (!dm.RspValid && w < 200) begin @(negedge clk); w++; end
        repeat (5) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(dm.RspValid), 64'd1);
        end
        rdy_mode = 2;
        w = 0;
        do begin @(negedge clk); w++; end while (!(dm.RspValid && dm.RspReady) && w < 20);
        @(negedge clk);
        chk("ready_after_hs", 64'(dm.ReqReady), 64'd1);
        rdy_mode = 0;

        // Random traffic.
        for (int n = 0; n < 80; n++) begin
            do_cmd(1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) != 0), 0, acc);
        end
        wait_done();
        for (int i = 1; i < 32; i++) chk("final_gpr", 64'(gpr[i]), 64'(ref_gpr[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
